and4_share_arbiter: RTL and testbench

Round-robin arbiter that shares a single 4-input AND reduction unit between four requesters. It grants exclusive use of the unit to one requester at a time and rotates priority so that no requester starves. A maximum-hold limit forces release from a requester that keeps its request asserted too long. It sits between the four client blocks and the shared AND unit's operand mux, which is driven by `owner` and qualified by `busy`.

---
 rtl/and4_share_arbiter.sv | 133 +++++++++++++
 tb/tb_and4_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and4_share_arbiter.sv
// ============================================================================
// Module   : and4_share_arbiter
// Purpose  : Round-robin arbiter granting one of four requesters exclusive use
//            of a shared 4-input AND reduction unit. Priority rotates past the
//            most recently released requester, and a hold limit forces a
//            release from a requester that keeps its request up too long.
// Ports    : clk     - rising-edge clock
//            rst     - asynchronous active-high reset
//            req     - level request per requester (bit i = requester i)
//            grant   - registered one-hot grant, zero when idle
//            owner   - index of the current / last granted requester
//            busy    - high while any grant is active (OR of grant)
//            timeout - one-cycle pulse on a hold-limit forced release
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module and4_share_arbiter #(
  parameter int MAX_HOLD = 16  // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value at which the grant has been held for MAX_HOLD cycles.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_next;
  logic [7:0]  hold_cnt, hold_next;
  logic [1:0]  last, last_next;
  logic [3:0]  grant_next;
  logic [1:0]  owner_next;
  logic        timeout_next;

  logic [3:0]  rot_req;   // req rotated so bit 0 is requester last+1
  logic [1:0]  rot_pos;   // first set position within rot_req
  logic [1:0]  pick_idx;  // winning requester index

  // Rotate the request vector so the search always starts just past the
  // last released requester; the 2-bit index arithmetic wraps mod 4.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rot_req[k] = req[last + 2'(k + 1)];
    end
  end

  // Lowest set position wins; scan high-to-low so the last write is lowest.
  always_comb begin
    rot_pos = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        rot_pos = 2'(k);
      end
    end
  end

  assign pick_idx = last + 2'd1 + rot_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      owner    <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
      last     <= 2'd3;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      owner    <= owner_next;
      busy     <= |grant_next;
      timeout  <= timeout_next;
      hold_cnt <= hold_next;
      last     <= last_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    owner_next   = owner;
    hold_next    = hold_cnt;
    last_next    = last;
    timeout_next = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          grant_next = 4'b0001 << pick_idx;
          owner_next = pick_idx;
          hold_next  = 8'd0;
          state_next = GRANT;
        end else begin
          grant_next = 4'b0000;
        end
      end

      GRANT: begin
        if (!req[owner]) begin
          grant_next = 4'b0000;
          last_next  = owner;
          state_next = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          grant_next   = 4'b0000;
          last_next    = owner;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          hold_next = hold_cnt + 8'd1;
        end
      end

      default: begin
        grant_next = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_and4_share_arbiter.sv
`default_nettype none

module tb_and4_share_arbiter;

  localparam int MAX_HOLD = 4;
  // A continuously asserted requester may sit through the cycle in which its
  // request is first arbitrated (or its own forced-release dead cycle) plus
  // three full services of MAX_HOLD grant cycles and one dead cycle each.
  localparam int STARVE_LIMIT = 3 * (MAX_HOLD + 1) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  and4_share_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the unit, for how many cycles, and who was
  // released last. Priority is a plain modular scan from last+1.
  logic [3:0] m_grant   = 4'b0000;
  int         m_owner   = 0;
  int         m_last    = 3;
  int         m_held    = 0;
  logic       m_timeout = 1'b0;
  int         m_idx;
  bit         m_found;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_grant   = 4'b0000;
      m_owner   = 0;
      m_last    = 3;
      m_held    = 0;
      m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_grant == 4'b0000) begin
        m_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          m_idx = (m_last + k) % 4;
          if (!m_found && req[m_idx]) begin
            m_found = 1'b1;
            m_owner = m_idx;
            m_grant = 4'b0000;
            m_grant[m_idx] = 1'b1;
            m_held  = 1;
          end
        end
      end else if (!req[m_owner]) begin
        m_last  = m_owner;
        m_grant = 4'b0000;
      end else if (m_held == MAX_HOLD) begin
        m_last    = m_owner;
        m_grant   = 4'b0000;
        m_timeout = 1'b1;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: grant=%b busy=%b timeout=%b owner=%0d required 0000/0/0/0",
               grant, busy, timeout, owner);
    end
    rst = 1'b0;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b owner=%0d busy=%b required 0100/2/1",
               grant, owner, busy);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release: grant=%b busy=%b required 0000/0", grant, busy);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev = 4'b0000;
    int n = 0;
    int cnt = 0;
    int gap = 0;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      if (grant != 4'b0000) begin
        if (grant != prev) begin
          checks++;
          if (grant !== exp_seq[n]) begin
            failures++;
            $display("FAIL rr_order[%0d]: grant=%b required %b", n, grant, exp_seq[n]);
          end
          if (n > 0) begin
            checks++;
            if (gap !== 1) begin
              failures++;
              $display("FAIL rr_gap[%0d]: idle cycles=%0d required 1", n, gap);
            end
          end
          n++;
          cnt = 0;
          gap = 0;
        end
        cnt++;
        prev = grant;
        if (cnt == 3) req = 4'b1111 & ~grant;
      end else begin
        gap++;
        prev = 4'b0000;
        req  = 4'b1111;
      end
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL rr_budget: grants seen=%0d required 5", n);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL rot_first: grant=%b required 0010", grant);
    end
    req = 4'b1011;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL rot_hold: grant=%b required 0010", grant);
    end
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL rot_dead: grant=%b required 0000", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      failures++;
      $display("FAIL rot_next: grant=%b owner=%0d required 1000/3", grant, owner);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                               4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic       exp_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== exp_g[c] || timeout !== exp_t[c]) begin
        failures++;
        $display("FAIL timeout_seq[%0d]: grant=%b timeout=%b required %b/%b",
                 c, grant, timeout, exp_g[c], exp_t[c]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL areset_pre: grant=%b required 1000", grant);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL areset_clear: grant=%b busy=%b timeout=%b required 0000/0/0",
               grant, busy, timeout);
    end
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL areset_resume: grant=%b owner=%0d required 0001/0", grant, owner);
    end
  endtask

  task automatic test_soak();
    int run = 0;
    int wait_cnt [4] = '{0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== m_grant || timeout !== m_timeout) begin
        failures++;
        $display("FAIL soak_model[%0d]: grant=%b timeout=%b required %b/%b",
                 c, grant, timeout, m_grant, m_timeout);
      end
      checks++;
      if (owner !== 2'(m_owner)) begin
        failures++;
        $display("FAIL soak_owner[%0d]: owner=%0d required %0d", c, owner, m_owner);
      end
      checks++;
      if ((grant & (grant - 4'd1)) !== 4'b0000 || busy !== (|grant)) begin
        failures++;
        $display("FAIL soak_onehot_busy[%0d]: grant=%b busy=%b", c, grant, busy);
      end
      checks++;
      if (busy === 1'b1 && grant !== (4'b0001 << owner)) begin
        failures++;
        $display("FAIL soak_owner_match[%0d]: grant=%b owner=%0d", c, grant, owner);
      end
      run = (grant != 4'b0000) ? run + 1 : 0;
      checks++;
      if (run > MAX_HOLD) begin
        failures++;
        $display("FAIL soak_hold[%0d]: held=%0d limit %0d", c, run, MAX_HOLD);
      end
      for (int i = 0; i < 4; i++) begin
        if (grant[i] || !req[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
      end
      checks++;
      if (wait_cnt[0] > STARVE_LIMIT || wait_cnt[1] > STARVE_LIMIT ||
          wait_cnt[2] > STARVE_LIMIT || wait_cnt[3] > STARVE_LIMIT) begin
        failures++;
        $display("FAIL soak_starve[%0d]: waits=%0d,%0d,%0d,%0d limit %0d", c,
                 wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3], STARVE_LIMIT);
      end
      // Sticky requests: raise with p=1/4, drop with p=1/8.
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ($urandom_range(7) == 0) req[i] = 1'b0;
        end else begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_rotation();
    test_timeout();
    test_async_reset();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
